mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Byte-wide RAM controller and arbiter that shares the single 8-bit memory port between the instruction-fetch stage and the MEM stage. It accepts whole-access requests (IF: 32-bit instruction word; MEM: 1/2/4-byte load or store) and sequences the individual byte cycles on the RAM port. It returns the assembled little-endian data with a one-cycle done pulse. It sits in the CPU top between the pipeline stages and the RAM, and replaces per-stage byte sequencing.

## Interface
Parameters:
- none; widths are fixed by the ISA (32-bit address/data, 8-bit RAM port).

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- if_req_i  in  1  IF requests a 32-bit instruction word; level, held until if_done_o
- if_addr_i  in  32  fetch byte address; sampled at accept
- if_flush_i  in  1  jump/branch taken: abort or suppress the IF transfer
- if_done_o  out  1  one-cycle pulse; if_inst_o valid
- if_inst_o  out  32  assembled instruction; holds until the next if_done_o
- mem_req_i  in  1  MEM requests a load/store; level, held until mem_done_o
- mem_we_i  in  1  1 = store, 0 = load
- mem_len_i  in  2  00 = 1 B, 01 = 2 B, 10/11 = 4 B
- mem_addr_i  in  32  first byte address; sampled at accept
- mem_wdata_i  in  32  store data, byte 0 = [7:0]; sampled at accept
- mem_done_o  out  1  one-cycle pulse; load data valid or store complete
- mem_rdata_o  out  32  load data, zero-extended; holds until the next load done
- ram_addr_o  out  32  RAM byte address
- ram_wr_o  out  1  1 = write ram_dout_o at ram_addr_o this cycle
- ram_dout_o  out  8  RAM write byte
- ram_din_i  in  8  RAM read byte; valid the cycle after its address is presented

## Operation
- States: IDLE, IF_RD, MEM_RD, MEM_WR, FIN.
- IDLE arbitration at each edge:
  - If mem_req_i is high, accept MEM (MEM_RD or MEM_WR by mem_we_i).
  - Else, if if_req_i is high and if_flush_i is low, accept IF (IF_RD).
  - Else, stay in IDLE.
  - MEM always wins a tie. Arbitration is non-preemptive.
- Accept latches the address, length N (IF: 4), write data, and the target port. Byte counter i = 0.
- Reads: byte i address = base + i (32-bit wrap, no alignment requirement). ram_addr_o = base + i is presented in read cycle i, i = 0..N-1. ram_din_i is captured at the end of cycle i+1 into byte lane i. The last byte is captured at the end of cycle N, then FIN.
- Writes: in cycle i, drive ram_addr_o = base + i, ram_dout_o = wdata byte i, ram_wr_o = 1. After cycle N-1, go to FIN.
- FIN (one cycle):
  - Pulse the done output of the owning port; rdata/inst are registered outputs valid in this cycle.
  - No arbitration in FIN; go to IDLE. The requester drops req on the edge ending FIN.
- Load assembly: little-endian; unfilled upper bytes = 0 (sign extension is MEM's job).
- if_flush_i while in IF_RD: abort at the next edge to IDLE, with no if_done_o and if_inst_o unchanged. A new IF request can be accepted from IDLE on the following edge.
- if_flush_i during MEM_RD, MEM_WR or FIN: no effect.
- ram_wr_o = 0 in every state except MEM_WR. ram_addr_o holds its last value when idle.

## Timing
- Reset (async, rst = 0): state IDLE; every output = 0 (if_done_o, if_inst_o, mem_done_o, mem_rdata_o, ram_addr_o, ram_wr_o, ram_dout_o). Reset mid-transfer drops ram_wr_o immediately; the transfer is lost.
- Request accepted at edge E0; read cycle 0 follows E0.
- Read of N bytes: done high in the cycle after edge E(N+1).
  - Word: done in cycle 6 counting the accept cycle as 1; 4 RAM cycles plus 2.
- Write of N bytes: ram_wr_o high in cycles after E0..E(N-1); done in the cycle after E(N).
- Back-to-back throughput: one transfer, FIN, IDLE, then accept. A 1-cycle IDLE gap separates transfers.
- A pending IF request waits while MEM requests keep arriving. MEM requests are spaced by pipeline stalls, so no starvation guard is needed.

## Structure
- macro.vh gains: state encodings (MC_IDLE, MC_IF_RD, MC_MEM_RD, MC_MEM_WR, MC_FIN) and length codes (LEN_B = 2'b00, LEN_H = 2'b01, LEN_W = 2'b10).
- Single module, no sub-module. Internal registers: state, owner, base address, 2-bit byte counter, length, write buffer, read assembly buffer.

## Test plan
- Word fetch at if_addr 0x1000, RAM bytes 13 05 00 00 → if_inst_o = 0x00000513; if_done_o pulses once, in the 6th cycle after accept.
- Store word 0xDEADBEEF to 0x2002 → ram_wr_o high 4 consecutive cycles with addr/data (0x2002,EF)(0x2003,BE)(0x2004,AD)(0x2005,DE); mem_done_o one cycle later.
- Byte load at 0x20 (RAM = 0x80) and half load at 0x21 (RAM 0x80, 0x7F) → mem_rdata_o = 0x00000080, then 0x00007F80.
- if_req and mem_req asserted in the same IDLE cycle → MEM completes first; the IF transfer starts one cycle after FIN and returns the correct word.
- if_flush_i pulsed in the 2nd cycle of an IF fetch → no if_done_o and ram_wr_o stays 0. A new request to 0x3000 completes with the data at 0x3000.
- rst = 0 mid-store → ram_wr_o = 0 and all outputs = 0 immediately. After rst = 1, the first request is served normally.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-wide RAM controller.
//   mc_state_e : controller FSM states
//   LEN_*      : MEM access length codes
//   mc_xfer_t  : transfer latched at accept (base address, store data, byte count)
package mem_ctrl_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned RAM_W  = 8;
    localparam int unsigned CNT_W  = 3;

    // Access length codes on mem_len_i; 2'b11 is treated as a word.
    localparam logic [1:0] LEN_B = 2'b00;
    localparam logic [1:0] LEN_H = 2'b01;
    localparam logic [1:0] LEN_W = 2'b10;

    typedef enum logic [2:0] {
        MC_IDLE   = 3'd0,
        MC_IF_RD  = 3'd1,
        MC_MEM_RD = 3'd2,
        MC_MEM_WR = 3'd3,
        MC_FIN    = 3'd4
    } mc_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [CNT_W-1:0]  nbytes;
    } mc_xfer_t;

    // Number of RAM byte cycles for a MEM length code.
    function automatic logic [CNT_W-1:0] len_bytes(input logic [1:0] len);
        case (len)
            LEN_B:   return CNT_W'(1);
            LEN_H:   return CNT_W'(2);
            LEN_W:   return CNT_W'(4);
            default: return CNT_W'(4);
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Pipeline-side request/response signals and the byte-wide RAM port.
//   slave  : the controller (takes requests, drives RAM address/data)
//   master : the environment (IF/MEM stages and the RAM itself)
interface mem_ctrl_if;
    import mem_ctrl_pkg::*;

    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_flush_i;
    logic              if_done_o;
    logic [DATA_W-1:0] if_inst_o;

    logic              mem_req_i;
    logic              mem_we_i;
    logic [1:0]        mem_len_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [DATA_W-1:0] mem_wdata_i;
    logic              mem_done_o;
    logic [DATA_W-1:0] mem_rdata_o;

    logic [ADDR_W-1:0] ram_addr_o;
    logic              ram_wr_o;
    logic [RAM_W-1:0]  ram_dout_o;
    logic [RAM_W-1:0]  ram_din_i;

    modport slave (
        input  if_req_i, if_addr_i, if_flush_i,
        output if_done_o, if_inst_o,
        input  mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i,
        output mem_done_o, mem_rdata_o,
        output ram_addr_o, ram_wr_o, ram_dout_o,
        input  ram_din_i
    );

    modport master (
        output if_req_i, if_addr_i, if_flush_i,
        input  if_done_o, if_inst_o,
        output mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i,
        input  mem_done_o, mem_rdata_o,
        input  ram_addr_o, ram_wr_o, ram_dout_o,
        output ram_din_i
    );

endinterface

// File: rtl/mem_ctrl.sv
// Byte-wide RAM controller/arbiter shared by the IF and MEM stages.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : mem_ctrl_if.slave -- IF request/response, MEM request/response,
//          8-bit RAM port (read data valid the cycle after its address)
// MEM wins arbitration in IDLE; transfers are non-preemptive. Reads run
// N+1 cycles (address pipeline plus one capture cycle), writes N cycles,
// then a one-cycle FIN where the owner's done pulse is visible.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    mem_ctrl_if.slave bus
);

    mc_state_e         state;
    mc_xfer_t          xfer;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rbuf;

    logic [DATA_W-1:0] rbuf_next;
    logic [RAM_W-1:0]  wbyte_next;
    logic [ADDR_W-1:0] addr_next;
    logic [CNT_W-1:0]  cnt_inc;

    assign cnt_inc   = cnt + CNT_W'(1);
    assign addr_next = xfer.addr + ADDR_W'(cnt_inc);

    // In read cycle cnt the RAM returns byte cnt-1; merge it into its lane.
    always_comb begin
        rbuf_next = rbuf;
        case (cnt)
            CNT_W'(1): rbuf_next[7:0]   = bus.ram_din_i;
            CNT_W'(2): rbuf_next[15:8]  = bus.ram_din_i;
            CNT_W'(3): rbuf_next[23:16] = bus.ram_din_i;
            CNT_W'(4): rbuf_next[31:24] = bus.ram_din_i;
            default:   rbuf_next        = rbuf;
        endcase
    end

    // Store byte for the next write cycle (byte 0 is issued at accept).
    always_comb begin
        case (cnt)
            CNT_W'(0): wbyte_next = xfer.wdata[15:8];
            CNT_W'(1): wbyte_next = xfer.wdata[23:16];
            default:   wbyte_next = xfer.wdata[31:24];
        endcase
    end

    // Controller FSM with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= MC_IDLE;
            xfer            <= '0;
            cnt             <= '0;
            rbuf            <= '0;
            bus.if_done_o   <= 1'b0;
            bus.if_inst_o   <= '0;
            bus.mem_done_o  <= 1'b0;
            bus.mem_rdata_o <= '0;
            bus.ram_addr_o  <= '0;
            bus.ram_wr_o    <= 1'b0;
            bus.ram_dout_o  <= '0;
        end else begin
            bus.if_done_o  <= 1'b0;
            bus.mem_done_o <= 1'b0;
            case (state)
                MC_IDLE: begin
                    bus.ram_wr_o <= 1'b0;
                    if (bus.mem_req_i) begin
                        xfer <= '{addr: bus.mem_addr_i, wdata: bus.mem_wdata_i,
                                  nbytes: len_bytes(bus.mem_len_i)};
                        cnt            <= '0;
                        rbuf           <= '0;
                        bus.ram_addr_o <= bus.mem_addr_i;
                        if (bus.mem_we_i) begin
                            state          <= MC_MEM_WR;
                            bus.ram_wr_o   <= 1'b1;
                            bus.ram_dout_o <= bus.mem_wdata_i[7:0];
                        end else begin
                            state <= MC_MEM_RD;
                        end
                    end else if (bus.if_req_i && !bus.if_flush_i) begin
                        xfer <= '{addr: bus.if_addr_i, wdata: '0, nbytes: CNT_W'(4)};
                        cnt            <= '0;
                        rbuf           <= '0;
                        bus.ram_addr_o <= bus.if_addr_i;
                        state          <= MC_IF_RD;
                    end
                end

                MC_IF_RD, MC_MEM_RD: begin
                    rbuf <= rbuf_next;
                    if (state == MC_IF_RD && bus.if_flush_i) begin
                        // Aborted fetch: nothing reaches if_inst_o.
                        state <= MC_IDLE;
                    end else if (cnt == xfer.nbytes) begin
                        state <= MC_FIN;
                        if (state == MC_IF_RD) begin
                            bus.if_inst_o <= rbuf_next;
                            bus.if_done_o <= 1'b1;
                        end else begin
                            bus.mem_rdata_o <= rbuf_next;
                            bus.mem_done_o  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt_inc;
                        if (cnt_inc < xfer.nbytes) begin
                            bus.ram_addr_o <= addr_next;
                        end
                    end
                end

                MC_MEM_WR: begin
                    if (cnt_inc < xfer.nbytes) begin
                        cnt            <= cnt_inc;
                        bus.ram_addr_o <= addr_next;
                        bus.ram_dout_o <= wbyte_next;
                    end else begin
                        bus.ram_wr_o   <= 1'b0;
                        bus.mem_done_o <= 1'b1;
                        state          <= MC_FIN;
                    end
                end

                MC_FIN: begin
                    state <= MC_IDLE;
                end

                default: begin
                    state <= MC_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: directed requests push expected responses
// (data and arrival cycle) into queues; a negedge monitor pops and compares.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    typedef struct {
        logic [31:0] data;
        int unsigned cyc;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
        int unsigned cyc;
    } wr_t;

    logic        clk;
    logic        rst;
    int unsigned cyc;
    int          checks;
    int          failures;
    logic [31:0] last_load;
    bit          preloaded;

    rsp_t ifq[$];
    rsp_t memq[$];
    wr_t  wq[$];
    rsp_t mon_r;
    wr_t  mon_w;

    logic [7:0] ram [0:65535];

    mem_ctrl_if bus_i();

    mem_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_byte(input logic [15:0] a);
        case (a)
            16'h1000: return 8'h13;
            16'h1001: return 8'h05;
            16'h0020: return 8'h80;
            16'h0021: return 8'h80;
            16'h0022: return 8'h7F;
            16'hFFFE: return 8'h11;
            16'hFFFF: return 8'h22;
            16'h0000: return 8'h33;
            16'h0001: return 8'h44;
            16'h3000: return 8'h37;
            16'h3001: return 8'h12;
            16'h3002: return 8'hAB;
            16'h3003: return 8'hCD;
            default:  return 8'h00;
        endcase
    endfunction

    // Synchronous RAM model: read data appears the cycle after the address.
    always @(posedge clk) begin
        if (!preloaded) begin
            for (int a = 0; a < 65536; a++) ram[a] <= init_byte(16'(a));
            preloaded <= 1'b1;
        end else if (bus_i.ram_wr_o) begin
            ram[bus_i.ram_addr_o[15:0]] <= bus_i.ram_dout_o;
        end
        bus_i.ram_din_i <= ram[bus_i.ram_addr_o[15:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic miss(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    // Monitor: every done pulse and every RAM write must match the queues.
    always @(negedge clk) begin
        if (rst) begin
            if (bus_i.if_done_o) begin
                if (ifq.size() == 0) miss("if_done_unexpected");
                else begin
                    mon_r = ifq.pop_front();
                    chk("if_inst", bus_i.if_inst_o, mon_r.data);
                    chk("if_done_cycle", cyc, mon_r.cyc);
                end
            end
            if (bus_i.mem_done_o) begin
                if (memq.size() == 0) miss("mem_done_unexpected");
                else begin
                    mon_r = memq.pop_front();
                    chk("mem_rdata", bus_i.mem_rdata_o, mon_r.data);
                    chk("mem_done_cycle", cyc, mon_r.cyc);
                end
            end
            if (bus_i.ram_wr_o) begin
                if (wq.size() == 0) miss("ram_wr_unexpected");
                else begin
                    mon_w = wq.pop_front();
                    chk("ram_wr_addr", bus_i.ram_addr_o, mon_w.addr);
                    chk("ram_wr_data", 32'(bus_i.ram_dout_o), 32'(mon_w.data));
                    chk("ram_wr_cycle", cyc, mon_w.cyc);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_if_done"},   32'(bus_i.if_done_o),  32'd0);
        chk({tag, "_if_inst"},   bus_i.if_inst_o,       32'd0);
        chk({tag, "_mem_done"},  32'(bus_i.mem_done_o), 32'd0);
        chk({tag, "_mem_rdata"}, bus_i.mem_rdata_o,     32'd0);
        chk({tag, "_ram_addr"},  bus_i.ram_addr_o,      32'd0);
        chk({tag, "_ram_wr"},    32'(bus_i.ram_wr_o),   32'd0);
        chk({tag, "_ram_dout"},  32'(bus_i.ram_dout_o), 32'd0);
    endtask

    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] exp_inst);
        bit got;
        rsp_t r;
        @(negedge clk);
        r.data = exp_inst;
        r.cyc  = cyc + 6;
        ifq.push_back(r);
        bus_i.if_addr_i = addr;
        bus_i.if_req_i  = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus_i.if_done_o) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) miss("if_done_timeout");
        bus_i.if_req_i = 1'b0;
    endtask

    task automatic do_mem(input logic we, input logic [1:0] len, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata);
        bit got;
        int n;
        rsp_t r;
        wr_t w;
        @(negedge clk);
        n = (len == LEN_B) ? 1 : (len == LEN_H) ? 2 : 4;
        if (we) begin
            for (int i = 0; i < n; i++) begin
                w.addr = addr + 32'(i);
                w.data = 8'(wdata >> (8 * i));
                w.cyc  = cyc + 1 + i;
                wq.push_back(w);
            end
            r.data = last_load;
            r.cyc  = cyc + n + 1;
        end else begin
            r.data    = exp_rdata;
            r.cyc     = cyc + n + 2;
            last_load = exp_rdata;
        end
        memq.push_back(r);
        bus_i.mem_we_i    = we;
        bus_i.mem_len_i   = len;
        bus_i.mem_addr_i  = addr;
        bus_i.mem_wdata_i = wdata;
        bus_i.mem_req_i   = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus_i.mem_done_o) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) miss("mem_done_timeout");
        bus_i.mem_req_i = 1'b0;
        bus_i.mem_we_i  = 1'b0;
    endtask

    initial begin
        bit got;
        rsp_t r;
        wr_t w;
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        last_load = 32'd0;
        preloaded = 1'b0;
        rst       = 1'b0;
        bus_i.if_req_i    = 1'b0;
        bus_i.if_addr_i   = 32'd0;
        bus_i.if_flush_i  = 1'b0;
        bus_i.mem_req_i   = 1'b0;
        bus_i.mem_we_i    = 1'b0;
        bus_i.mem_len_i   = 2'b00;
        bus_i.mem_addr_i  = 32'd0;
        bus_i.mem_wdata_i = 32'd0;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;

        // Word fetch; store word; byte/half loads; wrapping word load; readback.
        do_fetch(32'h0000_1000, 32'h0000_0513);
        do_mem(1'b1, LEN_W, 32'h0000_2002, 32'hDEAD_BEEF, 32'd0);
        do_mem(1'b0, LEN_B, 32'h0000_0020, 32'd0, 32'h0000_0080);
        do_mem(1'b0, LEN_H, 32'h0000_0021, 32'd0, 32'h0000_7F80);
        do_mem(1'b0, LEN_W, 32'hFFFF_FFFE, 32'd0, 32'h4433_2211);
        do_mem(1'b0, 2'b11, 32'h0000_2002, 32'd0, 32'hDEAD_BEEF);

        // Simultaneous requests: MEM first, IF accepted one cycle after FIN.
        @(negedge clk);
        r.data = 32'h0000_0080; r.cyc = cyc + 3; memq.push_back(r);
        r.data = 32'h0000_0513; r.cyc = cyc + 10; ifq.push_back(r);
        last_load = 32'h0000_0080;
        bus_i.mem_we_i   = 1'b0;
        bus_i.mem_len_i  = LEN_B;
        bus_i.mem_addr_i = 32'h0000_0020;
        bus_i.mem_req_i  = 1'b1;
        bus_i.if_addr_i  = 32'h0000_1000;
        bus_i.if_req_i   = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus_i.mem_done_o) bus_i.mem_req_i = 1'b0;
            if (bus_i.if_done_o) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) miss("tie_timeout");
        bus_i.if_req_i  = 1'b0;
        bus_i.mem_req_i = 1'b0;

        // Flush in the second fetch cycle: no done, no write, inst unchanged.
        @(negedge clk);
        bus_i.if_addr_i = 32'h0000_3000;
        bus_i.if_req_i  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus_i.if_flush_i = 1'b1;
        bus_i.if_req_i   = 1'b0;
        @(negedge clk);
        bus_i.if_flush_i = 1'b0;
        chk("flush_inst_hold", bus_i.if_inst_o, 32'h0000_0513);
        do_fetch(32'h0000_3000, 32'hCDAB_1237);

        // Reset in the middle of a word store.
        @(negedge clk);
        w.addr = 32'h0000_2100; w.data = 8'h0D; w.cyc = cyc + 1;
        wq.push_back(w);
        bus_i.mem_we_i    = 1'b1;
        bus_i.mem_len_i   = LEN_W;
        bus_i.mem_addr_i  = 32'h0000_2100;
        bus_i.mem_wdata_i = 32'hCAFE_F00D;
        bus_i.mem_req_i   = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        bus_i.mem_req_i = 1'b0;
        bus_i.mem_we_i  = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        last_load = 32'd0;
        do_mem(1'b0, LEN_H, 32'h0000_2100, 32'd0, 32'h0000_000D);

        repeat (5) @(negedge clk);
        chk("ifq_drained",  32'(ifq.size()),  32'd0);
        chk("memq_drained", 32'(memq.size()), 32'd0);
        chk("wq_drained",   32'(wq.size()),   32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule
